// File: rtl/alu_pkg.sv
// Shared ALU control encodings and the multiply sequencer state type.
package alu_pkg;

  localparam logic [1:0] ALU_OP_ARITH = 2'b00;
  localparam logic [1:0] ALU_OP_SHIFT = 2'b11;

  localparam logic [1:0] F_ADD = 2'b00;
  localparam logic [1:0] F_SLL = 2'b00;
  localparam logic [1:0] F_SRL = 2'b01;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ADD  = 3'd1,
    S_SHL  = 3'd2,
    S_SHR  = 3'd3,
    S_DONE = 3'd4
  } mul_state_e;

endpackage

// File: rtl/alu_mul_seq.sv
// Shift-and-add 8-bit truncated multiplier that borrows the shared ALU,
// issuing one ALU operation per cycle while Busy is high.
module alu_mul_seq
  import alu_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter bit EARLY_EXIT = 1'b1
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             Start,
  input  logic [WIDTH-1:0] OperandA,
  input  logic [WIDTH-1:0] OperandB,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Product,
  output logic [WIDTH-1:0] AluA,
  output logic [WIDTH-1:0] AluB,
  output logic [1:0]       AluOP,
  output logic [1:0]       AluFunc,
  input  logic [WIDTH-1:0] AluOut,
  input  logic             AluZero
);

  mul_state_e       state_q, state_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] product_q, product_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             exit_now;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q   <= S_IDLE;
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
    end
  end

  // ALU drive is a pure decode of registered state, so it is stable all cycle.
  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    AluA      = '0;
    AluB      = '0;
    AluOP     = ALU_OP_ARITH;
    AluFunc   = F_ADD;
    exit_now  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (Start) begin
          mcand_d  = OperandA;
          mplier_d = OperandB;
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = S_ADD;
        end
      end
      S_ADD: begin
        AluA = acc_q;
        AluB = mcand_q;
        if (mplier_q[0]) acc_d = AluOut;
        state_d = S_SHL;
      end
      S_SHL: begin
        AluOP   = ALU_OP_SHIFT;
        AluFunc = F_SLL;
        AluA    = mcand_q;
        AluB    = WIDTH'(1);
        mcand_d = AluOut;
        state_d = S_SHR;
      end
      S_SHR: begin
        AluOP    = ALU_OP_SHIFT;
        AluFunc  = F_SRL;
        AluA     = mplier_q;
        AluB     = WIDTH'(1);
        mplier_d = AluOut;
        cnt_d    = cnt_q + 4'd1;
        // Early exit: the shifted multiplier has no set bits left to add.
        if (EARLY_EXIT) exit_now = AluZero;
        else            exit_now = (cnt_q == 4'(WIDTH - 1));
        if (exit_now) begin
          product_d = acc_q;
          state_d   = S_DONE;
        end else begin
          state_d   = S_ADD;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign Busy    = (state_q == S_ADD) || (state_q == S_SHL) || (state_q == S_SHR);
  assign Done    = (state_q == S_DONE);
  assign Product = product_q;

endmodule

// File: tb/tb_alu_mul_seq.sv
// Bench for alu_mul_seq: early-exit and fixed-length instances share stimulus,
// each driving its own ALU and checked every cycle against a timeline model.
module tb_alu_mul_seq;

  logic            Clk;
  logic            Reset_n;
  logic            Start;
  logic [7:0]      opa, opb;
  logic [1:0]      busy, done, alu_zero;
  logic [1:0][7:0] prod, alu_a, alu_b, alu_out;
  logic [1:0][1:0] alu_op, alu_func;

  int n_checks = 0;
  int n_fail   = 0;

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  alu_mul_seq #(.WIDTH(8), .EARLY_EXIT(1'b1)) u_early (
    .Clk(Clk), .Reset_n(Reset_n), .Start(Start), .OperandA(opa), .OperandB(opb),
    .Busy(busy[0]), .Done(done[0]), .Product(prod[0]),
    .AluA(alu_a[0]), .AluB(alu_b[0]), .AluOP(alu_op[0]), .AluFunc(alu_func[0]),
    .AluOut(alu_out[0]), .AluZero(alu_zero[0]));

  alu_mul_seq #(.WIDTH(8), .EARLY_EXIT(1'b0)) u_full (
    .Clk(Clk), .Reset_n(Reset_n), .Start(Start), .OperandA(opa), .OperandB(opb),
    .Busy(busy[1]), .Done(done[1]), .Product(prod[1]),
    .AluA(alu_a[1]), .AluB(alu_b[1]), .AluOP(alu_op[1]), .AluFunc(alu_func[1]),
    .AluOut(alu_out[1]), .AluZero(alu_zero[1]));

  // Shared 8-bit ALU: ADD, SLL, SRL.
  function automatic logic [7:0] alu_calc(input logic [1:0] op, input logic [1:0] f,
                                          input logic [7:0] a, input logic [7:0] b);
    case ({op, f})
      4'b0000: return a + b;
      4'b1100: return a << b[2:0];
      4'b1101: return a >> b[2:0];
      default: return 8'h00;
    endcase
  endfunction

  always_comb begin
    for (int d = 0; d < 2; d++) begin
      alu_out[d]  = alu_calc(alu_op[d], alu_func[d], alu_a[d], alu_b[d]);
      alu_zero[d] = (alu_calc(alu_op[d], alu_func[d], alu_a[d], alu_b[d]) == 8'h00);
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Iteration count: index of highest set bit + 1 (min 1), or 8 in fixed mode.
  function automatic int calc_n(input logic [7:0] b, input bit early);
    if (!early) return 8;
    for (int i = 7; i >= 0; i--) if (b[i]) return i + 1;
    return 1;
  endfunction

  // Timeline model: mt = cycles into the busy window (-1 when not busy).
  int         mt[2];
  int         mn[2];
  bit         mdone[2];
  logic [7:0] ma[2], mb[2], mprod[2];

  always @(posedge Clk or negedge Reset_n) begin
    for (int d = 0; d < 2; d++) begin
      if (!Reset_n) begin
        mt[d] = -1; mn[d] = 1; mdone[d] = 1'b0; mprod[d] = 8'h00;
        ma[d] = 8'h00; mb[d] = 8'h00;
      end else if (mdone[d]) begin
        mdone[d] = 1'b0;
      end else if (mt[d] >= 0) begin
        mt[d]++;
        if (mt[d] == 3 * mn[d]) begin
          mt[d]    = -1;
          mdone[d] = 1'b1;
          mprod[d] = 8'((int'(ma[d]) * int'(mb[d])) % 256);
        end
      end else if (Start) begin
        mt[d] = 0; ma[d] = opa; mb[d] = opb; mn[d] = calc_n(opb, d == 0);
      end
    end
  end

  always @(negedge Clk) begin
    for (int d = 0; d < 2; d++) begin
      string tag;
      int k, ph, ia, ib;
      tag = $sformatf("dut%0d", d);
      chk({tag, " busy"}, busy[d], (mt[d] >= 0) ? 1 : 0);
      chk({tag, " done"}, done[d], mdone[d] ? 1 : 0);
      if (mt[d] < 0) begin
        chk({tag, " product"}, prod[d], mprod[d]);
        chk({tag, " idle_alu"}, {alu_op[d], alu_func[d], alu_a[d], alu_b[d]}, 0);
      end else begin
        k  = mt[d] / 3;
        ph = mt[d] % 3;
        ia = ma[d];
        ib = mb[d];
        case (ph)
          0: begin
            chk({tag, " add_opf"}, {alu_op[d], alu_func[d]}, 4'b0000);
            chk({tag, " add_a"}, alu_a[d], (ia * (ib % (1 << k))) % 256);
            chk({tag, " add_b"}, alu_b[d], (ia << k) % 256);
          end
          1: begin
            chk({tag, " shl_opf"}, {alu_op[d], alu_func[d]}, 4'b1100);
            chk({tag, " shl_a"}, alu_a[d], (ia << k) % 256);
            chk({tag, " shl_b"}, alu_b[d], 1);
          end
          default: begin
            chk({tag, " shr_opf"}, {alu_op[d], alu_func[d]}, 4'b1101);
            chk({tag, " shr_a"}, alu_a[d], ib >> k);
            chk({tag, " shr_b"}, alu_b[d], 1);
          end
        endcase
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge Clk);
  endtask

  // One request, then measure busy length, Done count and Product on both DUTs.
  task automatic run(input string name, input logic [7:0] a, input logic [7:0] b,
                     input int exp_be, input int exp_bf, input int exp_p);
    int bc[2], dc[2], pd[2];
    @(negedge Clk);
    opa = a; opb = b; Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
    bc = '{0, 0}; dc = '{0, 0}; pd = '{-1, -1};
    for (int c = 0; c < 30; c++) begin
      for (int d = 0; d < 2; d++) begin
        if (busy[d]) bc[d]++;
        if (done[d]) begin dc[d]++; pd[d] = prod[d]; end
      end
      @(negedge Clk);
    end
    chk({name, " busy_early"}, bc[0], exp_be);
    chk({name, " busy_full"}, bc[1], exp_bf);
    chk({name, " dones_early"}, dc[0], 1);
    chk({name, " dones_full"}, dc[1], 1);
    chk({name, " prod_early"}, pd[0], exp_p);
    chk({name, " prod_full"}, pd[1], exp_p);
  endtask

  initial begin
    int dcount;
    bit seen;
    Reset_n = 1'b0; Start = 1'b0; opa = 8'h00; opb = 8'h00;

    chk("pin_n_b3", calc_n(8'd3, 1'b1), 2);
    chk("pin_n_b0", calc_n(8'd0, 1'b1), 1);
    chk("pin_n_bff", calc_n(8'hff, 1'b1), 8);
    chk("pin_n_fixed", calc_n(8'd1, 1'b0), 8);

    cycles(3);
    #1;
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset prod", prod, 0);
    @(negedge Clk);
    Reset_n = 1'b1;

    run("a5b3", 8'd5, 8'd3, 6, 24, 15);
    run("a9b0", 8'd9, 8'd0, 3, 24, 0);
    run("affbff", 8'hff, 8'hff, 24, 24, 1);
    run("a6b1", 8'd6, 8'd1, 3, 24, 6);

    // Reset in the middle of 200*7.
    @(negedge Clk);
    opa = 8'd200; opb = 8'd7; Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
    cycles(3);
    #1;
    Reset_n = 1'b0;
    #1;
    chk("midreset busy", busy, 0);
    chk("midreset done", done, 0);
    chk("midreset prod", prod, 0);
    @(negedge Clk);
    Reset_n = 1'b1;
    run("a3b4", 8'd3, 8'd4, 9, 24, 12);

    // Start pulsed while busy is dropped.
    @(negedge Clk);
    opa = 8'd4; opb = 8'd4; Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
    cycles(2);
    opa = 8'd2; opb = 8'd2; Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
    dcount = 0;
    for (int c = 0; c < 30; c++) begin
      if (done[0]) begin dcount++; chk("ignored prod", prod[0], 16); end
      @(negedge Clk);
    end
    chk("ignored dones", dcount, 1);

    // Start held high across DONE: next accept only in the following IDLE cycle.
    opa = 8'd4; opb = 8'd4; Start = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 40 && !seen; c++) begin
      @(negedge Clk);
      if (done[0]) seen = 1'b1;
    end
    chk("held done seen", seen, 1);
    @(negedge Clk);
    chk("held idle gap", busy[0], 0);
    @(negedge Clk);
    chk("held reaccept", busy[0], 1);
    Start = 1'b0;
    cycles(40);

    // Randomized traffic, including requests while busy.
    for (int i = 0; i < 40; i++) begin
      opa = 8'($urandom_range(0, 255));
      opb = 8'($urandom_range(0, 255) >> $urandom_range(0, 7));
      Start = 1'b1;
      @(negedge Clk);
      Start = 1'b0;
      for (int c = 0; c < int'($urandom_range(0, 30)); c++) begin
        if ($urandom_range(0, 9) < 2) begin
          opa = 8'($urandom_range(0, 255));
          opb = 8'($urandom_range(0, 255));
          Start = 1'b1;
        end else begin
          Start = 1'b0;
        end
        @(negedge Clk);
      end
      Start = 1'b0;
    end
    cycles(40);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
